// File: rtl/led_share_arbiter.sv
// led_share_arbiter: round-robin owner selection for a shared LED bank.
// Each owner keeps the bank for at least DWELL cycles unless it lets go,
// and a one-cycle blank gap (SWITCH) separates consecutive owners.
// Optional build macro LED_SHARE_ARBITER_BLINK_EN adds a rotating idle
// heartbeat shown on the LEDs while nobody owns the bank.
module led_share_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LED_W   = 3,
  parameter int unsigned DWELL   = 200000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*LED_W-1:0]   req_pattern,
  output logic [NUM_REQ-1:0]         grant,
  output logic [LED_W-1:0]           led,
  output logic [$clog2(NUM_REQ)-1:0] owner_id,
  output logic                       busy
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(DWELL);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SWITCH
  } state_t;

  state_t               state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [LED_W-1:0]     led_q;
  logic [IW-1:0]        owner_q;
  logic                 busy_q;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;
  logic [IW-1:0]        ptr_q;
  logic [IW-1:0]        ptr_d;

  logic                 win_valid;
  logic [IW-1:0]        win_idx;
  logic [IW-1:0]        scan_idx;
  logic [NUM_REQ-1:0]   win_onehot;
  logic [LED_W-1:0]     win_pat;
  logic [LED_W-1:0]     own_pat;
  logic                 owner_req;
  logic                 others_req;
  logic                 dwell_done;
  logic [LED_W-1:0]     idle_led;

  // Winner: first requester at or above ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = IW'((32'(ptr_q) + i) % NUM_REQ);
      if (!win_valid && req[scan_idx]) begin
        win_valid = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Derived selection, pattern and dwell signals used by the FSM.
  always_comb begin
    win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
    win_pat    = req_pattern[win_idx*LED_W +: LED_W];
    own_pat    = req_pattern[owner_q*LED_W +: LED_W];
    owner_req  = req[owner_q];
    others_req = |(req & ~grant_q);
    dwell_done = (cnt_q == CNT_LAST);
    cnt_d      = dwell_done ? cnt_q : cnt_q + 1'b1;
    ptr_d      = (win_idx == IDX_LAST) ? '0 : win_idx + 1'b1;
  end

`ifdef LED_SHARE_ARBITER_BLINK_EN
  logic [LED_W-1:0] hb_q;
  logic [CW-1:0]    hb_cnt_q;

  // Free-running heartbeat: rotate the one-hot pattern left every DWELL cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      hb_q     <= LED_W'(1);
      hb_cnt_q <= '0;
    end else if (hb_cnt_q == CNT_LAST) begin
      hb_cnt_q <= '0;
      hb_q     <= {hb_q[LED_W-2:0], hb_q[LED_W-1]};
    end else begin
      hb_cnt_q <= hb_cnt_q + 1'b1;
    end
  end

  assign idle_led = hb_q;
`else
  assign idle_led = '0;
`endif

  // Ownership FSM; every output is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      led_q   <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            state_q <= HOLD;
            grant_q <= win_onehot;
            led_q   <= win_pat;
            owner_q <= win_idx;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            ptr_q   <= ptr_d;
          end else begin
            grant_q <= '0;
            led_q   <= idle_led;
            busy_q  <= 1'b0;
          end
        end
        HOLD: begin
          // Early release is checked first; pre-emption only after dwell.
          if (!owner_req || (dwell_done && others_req)) begin
            state_q <= SWITCH;
            grant_q <= '0;
            led_q   <= '0;
          end else begin
            led_q <= own_pat;
            cnt_q <= cnt_d;
          end
        end
        SWITCH: begin
          if (win_valid) begin
            state_q <= HOLD;
            grant_q <= win_onehot;
            led_q   <= win_pat;
            owner_q <= win_idx;
            cnt_q   <= '0;
            ptr_q   <= ptr_d;
          end else begin
            state_q <= IDLE;
            grant_q <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          led_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant    = grant_q;
  assign led      = led_q;
  assign owner_id = owner_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_led_share_arbiter.sv
// Directed bench for led_share_arbiter with NUM_REQ=4, LED_W=3, DWELL=4.
module tb_led_share_arbiter;

  localparam logic [11:0] PA = 12'b111_110_011_101;
  localparam logic [11:0] PB = 12'b111_110_011_010;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [11:0] req_pattern;
  logic [3:0]  grant;
  logic [2:0]  led;
  logic [1:0]  owner_id;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  rq;
    logic [11:0] pat;
    logic [3:0]  g;
    logic [2:0]  l;
    logic [1:0]  o;
    logic        b;
    string       nm;
  } vec_t;

  vec_t vecs[$];

  led_share_arbiter #(
    .NUM_REQ(4),
    .LED_W(3),
    .DWELL(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_pattern(req_pattern),
    .grant(grant),
    .led(led),
    .owner_id(owner_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] eg, input logic [2:0] el,
                     input logic [1:0] eo, input logic eb);
    logic [2:0] al;
    logic [2:0] ml;
    al = led;
    ml = el;
`ifdef LED_SHARE_ARBITER_BLINK_EN
    if (!eb) begin
      al = '0;
      ml = '0;
    end
`endif
    n_checks++;
    if ({grant, al, owner_id, busy} !== {eg, ml, eo, eb}) begin
      n_fail++;
      $display("FAIL %s: got grant=%b led=%b owner=%0d busy=%b, expected grant=%b led=%b owner=%0d busy=%b",
               nm, grant, led, owner_id, busy, eg, el, eo, eb);
    end
  endtask

  function automatic void add(input logic rst, input logic [3:0] rq, input logic [11:0] pat,
                              input logic [3:0] g, input logic [2:0] l, input logic [1:0] o,
                              input logic b, input string nm);
    vec_t v;
    v.rst = rst; v.rq = rq; v.pat = pat;
    v.g = g; v.l = l; v.o = o; v.b = b; v.nm = nm;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [11:0] pat_r;
    logic [2:0]  hb_a;
    logic [2:0]  hb_b;

    clk = 1'b0;
    reset = 1'b1;
    req = '0;
    req_pattern = PA;
    pat_r = PA;

    // Basic grant, long hold with saturated dwell, pattern change, release.
    add(0, 4'b0001, PA, 4'b0001, 3'b101, 0, 1, "a_grant");
    for (int i = 0; i < 12; i++) add(0, 4'b0001, PA, 4'b0001, 3'b101, 0, 1, "a_hold");
    add(0, 4'b0001, PB, 4'b0001, 3'b010, 0, 1, "a_patchg");
    add(0, 4'b0000, PB, 4'b0000, 3'b000, 0, 1, "a_rel");
    add(0, 4'b0000, PB, 4'b0000, 3'b000, 0, 0, "a_idle");
    // Pre-emption of owner 0 by requester 2 after exactly DWELL cycles.
    add(0, 4'b0001, PA, 4'b0001, 3'b101, 0, 1, "b_grant");
    for (int i = 0; i < 3; i++) add(0, 4'b0101, PA, 4'b0001, 3'b101, 0, 1, "b_dwell");
    add(0, 4'b0101, PA, 4'b0000, 3'b000, 0, 1, "b_gap");
    add(0, 4'b0101, PA, 4'b0100, 3'b110, 2, 1, "b_new");
    add(0, 4'b0000, PA, 4'b0000, 3'b000, 2, 1, "b_rel");
    add(0, 4'b0000, PA, 4'b0000, 3'b000, 2, 0, "b_idle");
    // Early release after one HOLD cycle.
    add(0, 4'b0001, PA, 4'b0001, 3'b101, 0, 1, "c_grant");
    add(0, 4'b0000, PA, 4'b0000, 3'b000, 0, 1, "c_switch");
    add(0, 4'b0000, PA, 4'b0000, 3'b000, 0, 0, "c_idle");
    // Reset mid-HOLD, then requester 0 wins after reset.
    add(0, 4'b0100, PA, 4'b0100, 3'b110, 2, 1, "d_grant");
    add(0, 4'b0100, PA, 4'b0100, 3'b110, 2, 1, "d_hold");
    add(1, 4'b0100, PA, 4'b0000, 3'b000, 0, 0, "d_reset");
    add(0, 4'b1111, PA, 4'b0001, 3'b101, 0, 1, "d_after");
    // Reset mid-SWITCH with requests pending; nothing remembered.
    add(0, 4'b0000, PA, 4'b0000, 3'b000, 0, 1, "e_switch");
    add(1, 4'b1111, PA, 4'b0000, 3'b000, 0, 0, "e_reset");
    add(0, 4'b0000, PA, 4'b0000, 3'b000, 0, 0, "e_idle");
    // Non-owner toggling before dwell is ignored; saturated hold; then pre-empt.
    add(0, 4'b0010, PA, 4'b0010, 3'b011, 1, 1, "f_grant");
    add(0, 4'b1010, PA, 4'b0010, 3'b011, 1, 1, "f_tog");
    add(0, 4'b0010, PA, 4'b0010, 3'b011, 1, 1, "f_tog");
    add(0, 4'b1010, PA, 4'b0010, 3'b011, 1, 1, "f_tog");
    add(0, 4'b0010, PA, 4'b0010, 3'b011, 1, 1, "f_sat");
    add(0, 4'b0010, PA, 4'b0010, 3'b011, 1, 1, "f_sat");
    add(0, 4'b1010, PA, 4'b0000, 3'b000, 1, 1, "f_gap");
    add(0, 4'b1010, PA, 4'b1000, 3'b111, 3, 1, "f_next");
    add(0, 4'b0000, PA, 4'b0000, 3'b000, 3, 1, "f_rel");
    add(0, 4'b0000, PA, 4'b0000, 3'b000, 3, 0, "f_idle");

    // Reset for 3 cycles, then 20 quiet idle cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset", 4'b0000, 3'b000, 0, 0);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle", 4'b0000, 3'b000, 0, 0);
    end

`ifdef LED_SHARE_ARBITER_BLINK_EN
    hb_a = led;
    n_checks++;
    if ($countones(hb_a) != 1) begin
      n_fail++;
      $display("FAIL hb_onehot: got led=%b, expected a one-hot value", hb_a);
    end
    for (int j = 0; j < 3; j++) begin
      repeat (4) tick();
      hb_b = led;
      n_checks++;
      if (hb_b !== {hb_a[1:0], hb_a[2]}) begin
        n_fail++;
        $display("FAIL hb_rotate: got led=%b, expected %b", hb_b, {hb_a[1:0], hb_a[2]});
      end
      hb_a = hb_b;
    end
`else
    hb_a = '0;
    hb_b = '0;
`endif

    foreach (vecs[k]) begin
      reset = vecs[k].rst;
      req = vecs[k].rq;
      req_pattern = vecs[k].pat;
      tick();
      chk(vecs[k].nm, vecs[k].g, vecs[k].l, vecs[k].o, vecs[k].b);
    end

    // All four requesting: strict rotation, DWELL cycles each, one-cycle gaps.
    reset = 1'b1;
    req = '0;
    req_pattern = PA;
    tick();
    chk("r_reset", 4'b0000, 3'b000, 0, 0);
    reset = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int o;
      o = k % 4;
      for (int c = 0; c < 4; c++) begin
        tick();
        chk("r_hold", 4'(1 << o), pat_r[o*3 +: 3], 2'(o), 1'b1);
      end
      if (k < 4) begin
        tick();
        chk("r_gap", 4'b0000, 3'b000, 2'(o), 1'b1);
      end
    end
    req = '0;
    tick();
    chk("r_rel", 4'b0000, 3'b000, 0, 1);
    tick();
    chk("r_idle", 4'b0000, 3'b000, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
